rr_mux_arbiter: RTL and testbench

// Round-robin arbiter that shares one WIDTH-bit 2:1 mux datapath between two

---
 rtl/rr_mux_arbiter.sv | 144 ++++++++++++++
 tb/tb_rr_mux_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter
// Description : Two-requester round-robin arbiter owning a shared 2:1 mux,
//               granting per burst and presenting beats on a valid/ready port.
//               Optional ARB_BURST_LIMIT_EN forces release after MAX_BURST beats.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter #(
    parameter int WIDTH     = 2,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             last0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             last1,
    output logic             gnt1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_OWN0 = 2'd1;
    localparam logic [1:0] c_ST_OWN1 = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_ptr;
    logic       w_ptr_nxt;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_sel;
    logic       w_own;
    logic       w_xfer;
    logic       w_end;
    logic       w_limit;

    // Datapath: only the owner is ever visible; IDLE drives zeros.
    assign w_own     = r_gnt0 | r_gnt1;
    assign out_valid = (r_gnt0 & req0) | (r_gnt1 & req1);
    assign out_data  = w_own ? (r_sel ? data1 : data0) : '0;
    assign out_last  = w_own & (r_sel ? last1 : last0);

    assign w_xfer = out_valid & out_ready;
    assign w_end  = w_xfer & (out_last | w_limit);

`ifdef ARB_BURST_LIMIT_EN
    localparam int c_CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [c_CNT_W-1:0] r_beat_cnt;

    assign w_limit = (r_beat_cnt == c_CNT_W'(MAX_BURST - 1));

    // Every ownership change passes through w_end, so clearing there also
    // clears the count on each grant change.
    always_ff @(posedge clk) begin
        if (rst || w_end) begin
            r_beat_cnt <= '0;
        end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
        end
    end
`else
    logic w_unused_cfg;

    // MAX_BURST only matters when the burst limit is built in.
    assign w_unused_cfg = (MAX_BURST > 0);
    assign w_limit      = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            c_ST_IDLE: begin
                if (req0 && req1) begin
                    w_state_nxt = r_ptr ? c_ST_OWN1 : c_ST_OWN0;
                end else if (req0) begin
                    w_state_nxt = c_ST_OWN0;
                end else if (req1) begin
                    w_state_nxt = c_ST_OWN1;
                end
            end
            c_ST_OWN0: begin
                if (w_end) begin
                    w_ptr_nxt = 1'b1;
                    if (req1) begin
                        w_state_nxt = c_ST_OWN1;
                    end else if (req0) begin
                        w_state_nxt = c_ST_OWN0;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            c_ST_OWN1: begin
                if (w_end) begin
                    w_ptr_nxt = 1'b0;
                    if (req0) begin
                        w_state_nxt = c_ST_OWN0;
                    end else if (req1) begin
                        w_state_nxt = c_ST_OWN1;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Grant and select are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_ptr   <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt0  <= (w_state_nxt == c_ST_OWN0);
            r_gnt1  <= (w_state_nxt == c_ST_OWN1);
            r_sel   <= (w_state_nxt == c_ST_OWN1);
        end
    end

    assign gnt0 = r_gnt0;
    assign gnt1 = r_gnt1;
    assign sel  = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux_arbiter
// Description : Directed scoreboard bench for rr_mux_arbiter; expected beats
//               are queued by the stimulus and popped by a separate monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

    localparam int WIDTH     = 2;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             last0;
    logic             gnt0;
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             last1;
    logic             gnt1;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;

    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH+1:0] mon_e;
    int               n_pass  = 0;
    int               n_total = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .data0     (data0),
        .last0     (last0),
        .gnt0      (gnt0),
        .req1      (req1),
        .data1     (data1),
        .last1     (last1),
        .gnt1      (gnt1),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic s, input logic [WIDTH-1:0] d, input logic l);
        exp_q.push_back({s, d, l});
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
        out_ready = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // Monitor: every accepted beat must match the head of the queue as {sel,data,last}.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_beat: got 0x%0h, expected no beat", {sel, out_data, out_last});
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat", 32'({sel, out_data, out_last}), 32'(mon_e));
            end
        end
    end

    initial begin
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; out_ready = 1'b0;
        data0 = '0; data1 = '0; last0 = 1'b0; last1 = 1'b0;

        // Reset with both requesting
        cyc(); cyc();
        chk("rst_gnt0",  32'(gnt0),      32'd0);
        chk("rst_gnt1",  32'(gnt1),      32'd0);
        chk("rst_sel",   32'(sel),       32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        rst = 1'b0;
        cyc();
        chk("rel_gnt0", 32'(gnt0), 32'd1);
        chk("rel_gnt1", 32'(gnt1), 32'd0);
        do_reset();

        // Single burst from requester 0
        push(1'b0, 2'b01, 1'b0); push(1'b0, 2'b10, 1'b0); push(1'b0, 2'b11, 1'b1);
        req0 = 1'b1; data0 = 2'b01; last0 = 1'b0;
        #1 chk("sb_idle_before_grant", 32'(out_valid), 32'd0);
        cyc();
        chk("sb_gnt0", 32'(gnt0), 32'd1);
        cyc(); data0 = 2'b10;
        cyc(); data0 = 2'b11; last0 = 1'b1;
        cyc(); req0 = 1'b0; last0 = 1'b0;
        #1 chk("sb_after_valid", 32'(out_valid), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        do_reset();

        // Contention: alternating 2-beat bursts, no bubble
        push(1'b0, 2'b00, 1'b0); push(1'b0, 2'b01, 1'b1);
        push(1'b1, 2'b11, 1'b0); push(1'b1, 2'b10, 1'b1);
        push(1'b0, 2'b10, 1'b0); push(1'b0, 2'b11, 1'b1);
        req0 = 1'b1; data0 = 2'b00; last0 = 1'b0;
        req1 = 1'b1; data1 = 2'b11; last1 = 1'b0;
        cyc();
        chk("ct_gnt0_a", 32'(gnt0), 32'd1);
        chk("ct_gnt1_a", 32'(gnt1), 32'd0);
        cyc(); data0 = 2'b01; last0 = 1'b1;
        cyc(); data0 = 2'b10; last0 = 1'b0;
        chk("ct_gnt1_b", 32'(gnt1), 32'd1);
        #1 chk("ct_no_bubble", 32'(out_valid), 32'd1);
        cyc(); data1 = 2'b10; last1 = 1'b1;
        cyc(); req1 = 1'b0; last1 = 1'b0;
        chk("ct_gnt0_c", 32'(gnt0), 32'd1);
        cyc(); data0 = 2'b11; last0 = 1'b1;
        cyc(); req0 = 1'b0; last0 = 1'b0;
        #1 chk("ct_drained", 32'(exp_q.size()), 32'd0);
        do_reset();

        // Owner drops req mid-burst, then backpressure
        push(1'b1, 2'b01, 1'b0); push(1'b1, 2'b10, 1'b1);
        req1 = 1'b1; data1 = 2'b01; last1 = 1'b0;
        cyc();
        cyc(); req1 = 1'b0; req0 = 1'b1; data0 = 2'b11; last0 = 1'b1;
        #1 chk("bp_drop_valid", 32'(out_valid), 32'd0);
        cyc();
        chk("bp_drop_gnt1", 32'(gnt1), 32'd1);
        chk("bp_drop_gnt0", 32'(gnt0), 32'd0);
        req0 = 1'b0; last0 = 1'b0; req1 = 1'b1; data1 = 2'b10; last1 = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_data", 32'(out_data), 32'h2);
            chk("bp_sel",  32'(sel),      32'd1);
            chk("bp_gnt1", 32'(gnt1),     32'd1);
        end
        out_ready = 1'b1;
        cyc(); req1 = 1'b0; last1 = 1'b0;
        #1 chk("bp_drained", 32'(exp_q.size()), 32'd0);
        do_reset();

        // Long burst from requester 0 while requester 1 waits
        for (int i = 0; i < 6; i++) begin
            push(1'b0, WIDTH'(i), 1'b0);
`ifdef ARB_BURST_LIMIT_EN
            if (i == 3) push(1'b1, 2'b11, 1'b1);
`endif
        end
        req0 = 1'b1; data0 = 2'b00; last0 = 1'b0;
        req1 = 1'b1; data1 = 2'b11; last1 = 1'b1;
        cyc();
        for (int i = 0; i < 6; i++) begin
            data0 = WIDTH'(i);
            cyc();
`ifdef ARB_BURST_LIMIT_EN
            if (i == 3) begin
                chk("bl_handover_gnt1", 32'(gnt1), 32'd1);
                cyc();
            end else begin
                chk("bl_gnt0", 32'(gnt0), 32'd1);
            end
`else
            chk("bl_hold_gnt0", 32'(gnt0), 32'd1);
`endif
        end
        req0 = 1'b0; req1 = 1'b0; last1 = 1'b0;
        #1 chk("bl_drained", 32'(exp_q.size()), 32'd0);
        do_reset();

        // Reset mid-burst of requester 1 after the pointer has moved to it
        push(1'b0, 2'b10, 1'b1); push(1'b1, 2'b01, 1'b0);
        req0 = 1'b1; data0 = 2'b10; last0 = 1'b1;
        req1 = 1'b1; data1 = 2'b01; last1 = 1'b0;
        cyc();
        cyc(); req0 = 1'b0; last0 = 1'b0;
        chk("rm_gnt1_before", 32'(gnt1), 32'd1);
        cyc(); data1 = 2'b10; rst = 1'b1;
        cyc();
        chk("rm_gnt1",  32'(gnt1),      32'd0);
        chk("rm_sel",   32'(sel),       32'd0);
        chk("rm_valid", 32'(out_valid), 32'd0);
        chk("rm_drained", 32'(exp_q.size()), 32'd0);
        req0 = 1'b1; out_ready = 1'b0; rst = 1'b0;
        cyc();
        chk("rm_ptr_gnt0", 32'(gnt0), 32'd1);
        chk("rm_ptr_gnt1", 32'(gnt1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
